vga_term: RTL and testbench

- Character-terminal sequencer in front of the 80x30 `vga` character controller.
- Accepts a stream of 7-bit ASCII bytes from the CPU/ACIA side over a valid/ready handshake.
- Tracks the cursor and interprets the control codes CR, LF, BS, HT and FF.
- Drives the `vga` write and scroll ports, respecting its `ready_out` so no write or scroll is ever lost.

---
 rtl/vga_term_pkg.sv | 27 ++
 rtl/vga_term_cursor.sv | 52 +++++
 rtl/vga_term.sv | 121 ++++++++++++
 tb/tb_vga_term.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_term_pkg.sv
// Shared types and constants for the vga_term character-terminal sequencer.
package vga_term_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    SCROLL,
    SCROLL_WAIT,
    CLEAR
  } state_t;

  localparam int COLS_DEF = 80;
  localparam int ROWS_DEF = 30;

  localparam logic [6:0] CHR_BS  = 7'd8;
  localparam logic [6:0] CHR_HT  = 7'd9;
  localparam logic [6:0] CHR_LF  = 7'd10;
  localparam logic [6:0] CHR_FF  = 7'd12;
  localparam logic [6:0] CHR_CR  = 7'd13;
  localparam logic [6:0] CHR_SP  = 7'd32;
  localparam logic [6:0] CHR_DEL = 7'd127;

  function automatic logic is_printable(input logic [6:0] code);
    return (code >= CHR_SP) && (code < CHR_DEL);
  endfunction

endpackage

// File: rtl/vga_term_cursor.sv
// Next-cursor calculation for one incoming code; purely combinational.
module vga_term_cursor
  import vga_term_pkg::*;
#(
  parameter int COLS      = COLS_DEF,
  parameter int ROWS      = ROWS_DEF,
  parameter int TAB_WIDTH = 8
) (
  input  logic [4:0] row,
  input  logic [6:0] col,
  input  logic [6:0] code,
  output logic [4:0] next_row,
  output logic [6:0] next_col,
  output logic       need_scroll
);

  logic [7:0] tab_stop;
  logic       last_col;
  logic       last_row;

  // One extra bit so the stop past the last column can be detected and clamped.
  assign tab_stop = ({1'b0, col} | 8'(TAB_WIDTH - 1)) + 8'd1;
  assign last_col = (col == 7'(COLS - 1));
  assign last_row = (row == 5'(ROWS - 1));

  always_comb begin
    next_row    = row;
    next_col    = col;
    need_scroll = 1'b0;
    if (is_printable(code)) begin
      if (last_col) begin
        next_col = 7'd0;
        if (last_row) need_scroll = 1'b1;
        else          next_row    = row + 5'd1;
      end else begin
        next_col = col + 7'd1;
      end
    end else begin
      case (code)
        CHR_CR: next_col = 7'd0;
        CHR_LF: begin
          if (last_row) need_scroll = 1'b1;
          else          next_row    = row + 5'd1;
        end
        CHR_BS: if (col != 7'd0) next_col = col - 7'd1;
        CHR_HT: next_col = (tab_stop > 8'(COLS - 1)) ? 7'(COLS - 1) : tab_stop[6:0];
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vga_term.sv
// Character-terminal sequencer: accepts ASCII bytes, tracks the cursor and
// drives the write/scroll ports of the 80x30 vga character controller.
module vga_term
  import vga_term_pkg::*;
#(
  parameter int COLS      = COLS_DEF,
  parameter int ROWS      = ROWS_DEF,
  parameter int TAB_WIDTH = 8
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  input  logic       vga_ready_in,
  output logic       vga_write_out,
  output logic [4:0] vga_row_out,
  output logic [6:0] vga_col_out,
  output logic [6:0] vga_data_out,
  output logic       vga_scroll_out,
  output logic [4:0] cursor_row_out,
  output logic [6:0] cursor_col_out
);

  state_t     state;
  logic [6:0] code;
  logic       unused_bit7;
  logic       accept;
  logic [4:0] nxt_row;
  logic [6:0] nxt_col;
  logic       need_scroll;
  logic       pend_scroll;
  logic [4:0] clr_row;
  logic [6:0] clr_col;

  assign code        = data_in[6:0];
  assign unused_bit7 = data_in[7];
  assign ready_out   = (state == IDLE) & vga_ready_in;
  assign accept      = valid_in & ready_out;

  vga_term_cursor #(.COLS(COLS), .ROWS(ROWS), .TAB_WIDTH(TAB_WIDTH)) u_cursor (
    .row         (cursor_row_out),
    .col         (cursor_col_out),
    .code        (code),
    .next_row    (nxt_row),
    .next_col    (nxt_col),
    .need_scroll (need_scroll)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= IDLE;
      cursor_row_out <= '0;
      cursor_col_out <= '0;
      clr_row        <= '0;
      clr_col        <= '0;
      pend_scroll    <= 1'b0;
      vga_write_out  <= 1'b0;
      vga_scroll_out <= 1'b0;
      vga_row_out    <= '0;
      vga_col_out    <= '0;
      vga_data_out   <= '0;
    end else begin
      vga_write_out  <= 1'b0;
      vga_scroll_out <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cursor_row_out <= nxt_row;
            cursor_col_out <= nxt_col;
            if (is_printable(code)) begin
              vga_write_out <= 1'b1;
              vga_row_out   <= cursor_row_out;
              vga_col_out   <= cursor_col_out;
              vga_data_out  <= code;
              pend_scroll   <= need_scroll;
              state         <= WRITE;
            end else if (code == CHR_FF) begin
              clr_row <= '0;
              clr_col <= '0;
              state   <= CLEAR;
            end else if (need_scroll) begin
              state <= SCROLL;
            end
          end
        end
        WRITE: state <= pend_scroll ? SCROLL : IDLE;
        SCROLL: begin
          if (vga_ready_in) begin
            vga_scroll_out <= 1'b1;
            state          <= SCROLL_WAIT;
          end
        end
        // The pulse cycle itself is the mandatory one-cycle wait.
        SCROLL_WAIT: if (!vga_scroll_out && vga_ready_in) state <= IDLE;
        CLEAR: begin
          if (vga_ready_in) begin
            vga_write_out <= 1'b1;
            vga_row_out   <= clr_row;
            vga_col_out   <= clr_col;
            vga_data_out  <= CHR_SP;
            if (clr_col == 7'(COLS - 1)) begin
              clr_col <= '0;
              if (clr_row == 5'(ROWS - 1)) begin
                cursor_row_out <= '0;
                cursor_col_out <= '0;
                state          <= IDLE;
              end else begin
                clr_row <= clr_row + 5'd1;
              end
            end else begin
              clr_col <= clr_col + 7'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_term.sv
// Directed self-checking bench for vga_term with a simple vga ready model.
module tb_vga_term;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       vga_ready_in;
  logic       vga_write_out;
  logic [4:0] vga_row_out;
  logic [6:0] vga_col_out;
  logic [6:0] vga_data_out;
  logic       vga_scroll_out;
  logic [4:0] cursor_row_out;
  logic [6:0] cursor_col_out;

  int n_cmp = 0;
  int n_err = 0;

  int wr_cnt = 0;
  int sc_cnt = 0;
  logic clr_mon = 1'b0;
  logic tgl_en = 1'b0;
  int tgl_cnt = 0;
  int clr_wr = 0;
  int clr_dup = 0;
  int clr_bad_data = 0;
  int clr_bad_pos = 0;
  int clr_bad_rdy = 0;
  logic seen [30][80];

  vga_term dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .data_in        (data_in),
    .valid_in       (valid_in),
    .ready_out      (ready_out),
    .vga_ready_in   (vga_ready_in),
    .vga_write_out  (vga_write_out),
    .vga_row_out    (vga_row_out),
    .vga_col_out    (vga_col_out),
    .vga_data_out   (vga_data_out),
    .vga_scroll_out (vga_scroll_out),
    .cursor_row_out (cursor_row_out),
    .cursor_col_out (cursor_col_out)
  );

  always #20 clk_in = ~clk_in;

  // Strobe monitor plus the toggling ready model used during the clear.
  // A write seen here was decided at the preceding rising edge, which sampled
  // the vga_ready_in value still present before this block updates it.
  always @(negedge clk_in) begin
    if (vga_write_out) wr_cnt++;
    if (vga_scroll_out) sc_cnt++;
    if (clr_mon && vga_write_out) begin
      clr_wr++;
      if (!vga_ready_in) clr_bad_rdy++;
      if (vga_data_out != 7'h20) clr_bad_data++;
      if (vga_row_out >= 5'd30 || vga_col_out >= 7'd80) clr_bad_pos++;
      else if (seen[vga_row_out][vga_col_out]) clr_dup++;
      else seen[vga_row_out][vga_col_out] = 1'b1;
    end
    if (tgl_en) begin
      tgl_cnt++;
      if (tgl_cnt == 7) begin
        tgl_cnt = 0;
        vga_ready_in = ~vga_ready_in;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns 1 ns after the accepting edge.
  task automatic send(input logic [7:0] b);
    int n;
    @(negedge clk_in);
    data_in  = b;
    valid_in = 1'b1;
    n = 0;
    while (ready_out !== 1'b1 && n < 8000) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 8000) chk("send_timeout", {31'd0, ready_out}, 1);
    @(posedge clk_in);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic send_n(input logic [7:0] b, input int k);
    for (int i = 0; i < k; i++) send(b);
  endtask

  task automatic cyc(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  initial begin
    int w0, s0, n, cov;
    logic rdy_seen;
    rst_in = 1'b1; data_in = 8'h00; valid_in = 1'b0; vga_ready_in = 1'b1;
    #50;
    chk("rst_write", {31'd0, vga_write_out}, 0);
    chk("rst_scroll", {31'd0, vga_scroll_out}, 0);
    chk("rst_row", {27'd0, vga_row_out}, 0);
    chk("rst_col", {25'd0, vga_col_out}, 0);
    chk("rst_data", {25'd0, vga_data_out}, 0);
    chk("rst_cur", {20'd0, cursor_row_out, cursor_col_out}, 0);
    chk("rst_ready", {31'd0, ready_out}, 1);
    @(negedge clk_in); rst_in = 1'b0;

    // 'A' at origin
    w0 = wr_cnt;
    send(8'h41);
    chk("A_write", {31'd0, vga_write_out}, 1);
    chk("A_pos", {20'd0, vga_row_out, vga_col_out}, {20'd0, 5'd0, 7'd0});
    chk("A_data", {25'd0, vga_data_out}, 32'h41);
    chk("A_ready_n1", {31'd0, ready_out}, 0);
    chk("A_cursor", {20'd0, cursor_row_out, cursor_col_out}, {20'd0, 5'd0, 7'd1});
    cyc(1);
    chk("A_ready_n2", {31'd0, ready_out}, 1);
    chk("A_strobe_len", {31'd0, vga_write_out}, 0);
    cyc(2);
    chk("A_wr_count", wr_cnt - w0, 1);

    // Wrap without scroll at (5,79); bit 7 of the byte must be ignored
    send_n(8'h0A, 5);
    send_n(8'h09, 9);
    chk("tab_72", {25'd0, cursor_col_out}, 72);
    send_n(8'h78, 7);
    chk("pos_5_79", {20'd0, cursor_row_out, cursor_col_out}, {20'd0, 5'd5, 7'd79});
    s0 = sc_cnt;
    send(8'hDA);
    chk("Z_write", {31'd0, vga_write_out}, 1);
    chk("Z_pos", {20'd0, vga_row_out, vga_col_out}, {20'd0, 5'd5, 7'd79});
    chk("Z_data", {25'd0, vga_data_out}, 32'h5A);
    chk("Z_cursor", {20'd0, cursor_row_out, cursor_col_out}, {20'd0, 5'd6, 7'd0});
    cyc(6);
    chk("Z_no_scroll", sc_cnt - s0, 0);

    // Wrap with scroll at (29,79)
    send_n(8'h0A, 23);
    send_n(8'h09, 9);
    send_n(8'h78, 7);
    chk("pos_29_79", {20'd0, cursor_row_out, cursor_col_out}, {20'd0, 5'd29, 7'd79});
    s0 = sc_cnt;
    send(8'h51);
    chk("Q_pos", {20'd0, vga_row_out, vga_col_out}, {20'd0, 5'd29, 7'd79});
    chk("Q_data", {25'd0, vga_data_out}, 32'h51);
    n = 0;
    while (vga_scroll_out !== 1'b1 && n < 20) begin cyc(1); n++; end
    chk("Q_scroll_seen", {31'd0, vga_scroll_out}, 1);
    vga_ready_in = 1'b0;
    rdy_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (ready_out) rdy_seen = 1'b1;
    end
    chk("Q_ready_held_low", {31'd0, rdy_seen}, 0);
    @(negedge clk_in); vga_ready_in = 1'b1;
    cyc(2);
    chk("Q_ready_back", {31'd0, ready_out}, 1);
    chk("Q_scroll_count", sc_cnt - s0, 1);
    chk("Q_cursor", {20'd0, cursor_row_out, cursor_col_out}, {20'd0, 5'd29, 7'd0});

    // Control codes from (3,10)
    @(negedge clk_in); rst_in = 1'b1;
    @(negedge clk_in); rst_in = 1'b0;
    send_n(8'h0A, 3);
    send_n(8'h2E, 10);
    chk("pos_3_10", {20'd0, cursor_row_out, cursor_col_out}, {20'd0, 5'd3, 7'd10});
    cyc(2);
    w0 = wr_cnt;
    send(8'h09);
    chk("HT_col", {25'd0, cursor_col_out}, 16);
    send(8'h0D);
    chk("CR_col", {25'd0, cursor_col_out}, 0);
    chk("CR_ready_n1", {31'd0, ready_out}, 1);
    send(8'h08);
    chk("BS0_col", {25'd0, cursor_col_out}, 0);
    send(8'h0A);
    chk("LF_pos", {20'd0, cursor_row_out, cursor_col_out}, {20'd0, 5'd4, 7'd0});
    send(8'h7F);
    send(8'h01);
    chk("other_pos", {20'd0, cursor_row_out, cursor_col_out}, {20'd0, 5'd4, 7'd0});
    cyc(2);
    chk("ctrl_no_writes", wr_cnt - w0, 0);
    send_n(8'h2E, 3);
    send(8'h08);
    chk("BS3_col", {25'd0, cursor_col_out}, 2);

    // Full clear with ready toggling every 7 cycles
    foreach (seen[r, c]) seen[r][c] = 1'b0;
    clr_mon = 1'b1;
    tgl_en  = 1'b1;
    send(8'h0C);
    n = 0;
    while (clr_wr < 2400 && n < 8000) begin cyc(1); n++; end
    cyc(3);
    tgl_en  = 1'b0;
    clr_mon = 1'b0;
    @(negedge clk_in); vga_ready_in = 1'b1;
    cyc(2);
    cov = 0;
    foreach (seen[r, c]) if (seen[r][c]) cov++;
    chk("FF_writes", clr_wr, 2400);
    chk("FF_coverage", cov, 2400);
    chk("FF_dups", clr_dup, 0);
    chk("FF_bad_data", clr_bad_data, 0);
    chk("FF_bad_pos", clr_bad_pos, 0);
    chk("FF_write_when_not_ready", clr_bad_rdy, 0);
    chk("FF_cursor", {20'd0, cursor_row_out, cursor_col_out}, 0);
    chk("FF_ready", {31'd0, ready_out}, 1);

    // Reset in the middle of a clear
    send_n(8'h2E, 2);
    send(8'h0C);
    n = 0;
    while (!(vga_write_out === 1'b1 && vga_row_out == 5'd12) && n < 3000) begin cyc(1); n++; end
    chk("mid_clear_row12", {27'd0, vga_row_out}, 12);
    rst_in = 1'b1;
    #1;
    chk("mr_write", {31'd0, vga_write_out}, 0);
    chk("mr_row", {27'd0, vga_row_out}, 0);
    chk("mr_col", {25'd0, vga_col_out}, 0);
    chk("mr_data", {25'd0, vga_data_out}, 0);
    chk("mr_cursor", {20'd0, cursor_row_out, cursor_col_out}, 0);
    chk("mr_idle_ready", {31'd0, ready_out}, 1);
    @(negedge clk_in); rst_in = 1'b0;
    send(8'h42);
    chk("B_write", {31'd0, vga_write_out}, 1);
    chk("B_pos", {20'd0, vga_row_out, vga_col_out}, 0);
    chk("B_data", {25'd0, vga_data_out}, 32'h42);
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
